// File: rtl/mips_phase_sequencer_if.sv
// Run-control bundle between the MIPS phase sequencer (slave) and its controller (master).
interface mips_phase_sequencer_if #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned CNT_W      = 16
);
  logic                  start;
  logic                  abort;
  logic [31:0]           instruction;
  logic [NUM_PHASES-1:0] phase_en;
  logic                  step_done;
  logic [CNT_W-1:0]      cycle_count;
  logic                  running;
  logic                  halted;
  logic [1:0]            halt_cause;
  logic [4:0]            dump_addr;
  logic                  dump_valid;
  logic                  dump_ready;

  modport master (
    output start, abort, instruction, dump_ready,
    input  phase_en, step_done, cycle_count, running, halted, halt_cause, dump_addr, dump_valid
  );

  modport slave (
    input  start, abort, instruction, dump_ready,
    output phase_en, step_done, cycle_count, running, halted, halt_cause, dump_addr, dump_valid
  );
endinterface

// File: rtl/mips_phase_sequencer.sv
// Run controller for the MIPS single-cycle core: one-hot phase enables, step counting, halt logic.
// Optional register-dump state enabled by defining MIPS_PHASE_SEQ_DUMP_EN.
module mips_phase_sequencer #(
  parameter int unsigned              NUM_PHASES = 4,
  parameter logic [8*NUM_PHASES-1:0]  PHASE_LENS = {8'd1, 8'd5, 8'd5, 8'd1},
  parameter int unsigned              HALT_NOPS  = 3,
  parameter int unsigned              MAX_CYCLES = 100,
  parameter int unsigned              CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mips_phase_sequencer_if.slave seq_if
);

  localparam int unsigned PhW  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int unsigned NopW = $clog2(HALT_NOPS + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDump, StHalt} state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic [7:0]       tick_q, tick_d;
  logic [NopW-1:0]  nops_q, nops_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [4:0]       addr_q, addr_d;

  logic [7:0]       cur_len;
  logic             last_tick, last_phase, step_end;
  logic [NopW-1:0]  nops_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             nop_hit, lim_hit, dump_accept;

`ifdef MIPS_PHASE_SEQ_DUMP_EN
  localparam state_e HaltDest = StDump;
  assign dump_accept = (state_q == StDump) && seq_if.dump_ready;
`else
  localparam state_e HaltDest = StHalt;
  logic unused_dump_ready;
  assign dump_accept       = 1'b0;
  assign unused_dump_ready = seq_if.dump_ready;
`endif

  always_comb begin
    cur_len = PHASE_LENS[7:0];
    for (int p = 0; p < int'(NUM_PHASES); p++) begin
      if (phase_q == PhW'(p)) cur_len = PHASE_LENS[8*p +: 8];
    end
  end

  assign last_tick  = (tick_q == cur_len - 8'd1);
  assign last_phase = (phase_q == PhW'(NUM_PHASES - 1));
  assign step_end   = (state_q == StRun) && last_tick && last_phase;

  // Halt decisions look at the counters as they will be after this step completes.
  assign nops_upd = (seq_if.instruction == 32'd0) ? nops_q + NopW'(1) : '0;
  assign cnt_upd  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign nop_hit  = (nops_upd == NopW'(HALT_NOPS));
  assign lim_hit  = (cnt_upd == CNT_W'(MAX_CYCLES));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StHalt: if (seq_if.start) state_d = StRun;
      StRun: begin
        if (seq_if.abort || (step_end && (nop_hit || lim_hit))) state_d = HaltDest;
      end
      StDump: begin
        if (seq_if.abort || (dump_accept && (addr_q == 5'd31))) state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    tick_d  = tick_q;
    nops_d  = nops_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (seq_if.start) begin
          phase_d = '0;
          tick_d  = '0;
          nops_d  = '0;
          cnt_d   = '0;
          cause_d = 2'b00;
          addr_d  = '0;
        end
      end
      StRun: begin
        if (last_tick) begin
          tick_d  = '0;
          phase_d = last_phase ? '0 : phase_q + PhW'(1);
        end else begin
          tick_d = tick_q + 8'd1;
        end
        if (step_end) begin
          cnt_d  = cnt_upd;
          nops_d = nops_upd;
          if (nop_hit)      cause_d = 2'b01;
          else if (lim_hit) cause_d = 2'b10;
        end
        // Abort overrides any cause raised by a coincident step end.
        if (seq_if.abort) cause_d = 2'b11;
      end
      StDump: begin
        if (seq_if.abort)     addr_d = '0;
        else if (dump_accept) addr_d = addr_q + 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      tick_q  <= '0;
      nops_q  <= '0;
      cnt_q   <= '0;
      cause_q <= 2'b00;
      addr_q  <= '0;
    end else begin
      phase_q <= phase_d;
      tick_q  <= tick_d;
      nops_q  <= nops_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
    end
  end

  // Output logic
  always_comb begin
    seq_if.phase_en    = '0;
    if (state_q == StRun) seq_if.phase_en = NUM_PHASES'(1) << phase_q;
    seq_if.step_done   = step_end;
    seq_if.cycle_count = cnt_q;
    seq_if.running     = (state_q == StRun);
    seq_if.halted      = (state_q == StHalt);
    seq_if.halt_cause  = cause_q;
`ifdef MIPS_PHASE_SEQ_DUMP_EN
    seq_if.dump_addr   = addr_q;
    seq_if.dump_valid  = (state_q == StDump);
`else
    seq_if.dump_addr   = 5'd0;
    seq_if.dump_valid  = 1'b0;
`endif
  end

  a_phase_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(seq_if.phase_en));

endmodule

// File: tb/tb_mips_phase_sequencer.sv
// Randomised self-checking bench for mips_phase_sequencer against a cycle-offset reference model.
module tb_mips_phase_sequencer;
  localparam int NP   = 4;
  localparam int CW   = 16;
  localparam int HN   = 3;
  localparam int MC   = 100;
  localparam int STEP = 12;
`ifdef MIPS_PHASE_SEQ_DUMP_EN
  localparam bit DUMP = 1'b1;
`else
  localparam bit DUMP = 1'b0;
`endif

  int lens[NP] = '{1, 5, 5, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_phase_sequencer_if #(.NUM_PHASES(NP), .CNT_W(CW)) sif ();

  mips_phase_sequencer #(
    .NUM_PHASES(NP),
    .PHASE_LENS({8'd1, 8'd5, 8'd5, 8'd1}),
    .HALT_NOPS (HN),
    .MAX_CYCLES(MC),
    .CNT_W     (CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .seq_if(sif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 idle, 1 run, 2 dump, 3 halt; m_off = cycle offset inside the current step.
  int m_state, m_off, m_cnt, m_nops, m_cause, m_addr;

  function automatic int phase_of(int off);
    int acc = 0;
    for (int p = 0; p < NP; p++) begin
      if (off < acc + lens[p]) return p;
      acc += lens[p];
    end
    return 0;
  endfunction

  function automatic logic [30:0] exp_vec();
    logic [3:0] pe;
    pe = 4'd0;
    if (m_state == 1) pe = 4'd1 << phase_of(m_off);
    return {pe, (m_state == 1 && m_off == STEP - 1), 16'(m_cnt), (m_state == 1), (m_state == 3),
            2'(m_cause), (m_state == 2) ? 5'(m_addr) : 5'd0, (m_state == 2)};
  endfunction

  function automatic logic [30:0] obs_vec();
    return {sif.phase_en, sif.step_done, sif.cycle_count, sif.running, sif.halted,
            sif.halt_cause, sif.dump_addr, sif.dump_valid};
  endfunction

  task automatic model_adv(input bit st, input bit ab, input logic [31:0] ins, input bit rdy,
                           input bit rs);
    bit halt;
    halt = 1'b0;
    if (rs) begin
      m_state = 0; m_off = 0; m_cnt = 0; m_nops = 0; m_cause = 0; m_addr = 0;
      return;
    end
    case (m_state)
      0, 3: if (st) begin
        m_state = 1; m_off = 0; m_cnt = 0; m_nops = 0; m_cause = 0; m_addr = 0;
      end
      1: begin
        if (m_off == STEP - 1) begin
          m_off = 0;
          if (m_cnt < 65535) m_cnt++;
          m_nops = (ins == 32'd0) ? m_nops + 1 : 0;
          if (m_nops == HN) begin m_cause = 1; halt = 1'b1; end
          else if (m_cnt == MC) begin m_cause = 2; halt = 1'b1; end
        end else begin
          m_off++;
        end
        if (ab) begin m_cause = 3; halt = 1'b1; end
        if (halt) m_state = DUMP ? 2 : 3;
      end
      2: begin
        if (ab) begin m_state = 3; m_addr = 0; end
        else if (rdy) begin
          if (m_addr == 31) begin m_state = 3; m_addr = 0; end
          else m_addr++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick(input bit st, input bit ab, input logic [31:0] ins, input bit rdy,
                      input bit rs);
    sif.start = st; sif.abort = ab; sif.instruction = ins; sif.dump_ready = rdy; rst = rs;
    model_adv(st, ab, ins, rdy, rs);
    @(negedge clk);
    sif.start = 1'b0; sif.abort = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs_vec() !== 31'd0) begin
      n_fail++; $display("FAIL reset_state: got %h expected 0", obs_vec());
    end
    tick(1'b1, 1'b0, 32'd1, 1'b1, 1'b1);  // reset beats start
    n_checks++;
    if (sif.running !== 1'b0 || sif.phase_en !== 4'd0) begin
      n_fail++; $display("FAIL reset_over_start: got running=%b phase_en=%b expected 0/0000",
                         sif.running, sif.phase_en);
    end
  endtask

  task automatic test_phase_pattern();
    logic [3:0] pat [STEP];
    int n_sd;
    pat = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
            4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    n_sd = 0;
    tick(1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * STEP; i++) begin
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pattern_outputs cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      n_checks++;
      if (sif.phase_en !== pat[i % STEP]) begin
        n_fail++; $display("FAIL pattern_phase_en cyc %0d: got %b expected %b", i, sif.phase_en,
                           pat[i % STEP]);
      end
      if (sif.step_done === 1'b1) n_sd++;
      tick(1'b0, 1'b0, 32'd1, 1'b0, 1'b0);
    end
    n_checks++;
    if (n_sd != 3 || sif.cycle_count !== 16'd3) begin
      n_fail++; $display("FAIL pattern_count: got step_done=%0d count=%0d expected 3/3", n_sd,
                         sif.cycle_count);
    end
  endtask

  task automatic test_nop_halt();
    logic [31:0] ins;
    tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL nop_outputs cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (sif.running !== 1'b1) break;
      ins = (m_cnt < 4) ? ($urandom | 32'd1) : 32'd0;
      tick(1'b0, 1'b0, ins, 1'b1, 1'b0);
    end
    if (DUMP) for (int i = 0; i < 40 && sif.halted !== 1'b1; i++) tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
    n_checks++;
    if (sif.halted !== 1'b1 || sif.cycle_count !== 16'd7 || sif.halt_cause !== 2'b01 ||
        sif.phase_en !== 4'd0) begin
      n_fail++; $display("FAIL nop_halt: got halted=%b count=%0d cause=%b pe=%b expected 1/7/01/0000",
                         sif.halted, sif.cycle_count, sif.halt_cause, sif.phase_en);
    end
  endtask

  task automatic test_step_limit();
    tick(1'b1, 1'b0, 32'd5, 1'b0, 1'b0);
    for (int i = 0; i < 1300; i++) begin
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL limit_outputs cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (sif.running !== 1'b1) break;
      tick(1'b0, 1'b0, $urandom | 32'd1, 1'b1, 1'b0);
    end
    if (DUMP) for (int i = 0; i < 40 && sif.halted !== 1'b1; i++) tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
    n_checks++;
    if (sif.halted !== 1'b1 || sif.cycle_count !== 16'd100 || sif.halt_cause !== 2'b10) begin
      n_fail++; $display("FAIL step_limit: got halted=%b count=%0d cause=%b expected 1/100/10",
                         sif.halted, sif.cycle_count, sif.halt_cause);
    end
    tick(1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
    n_checks++;
    if (sif.cycle_count !== 16'd0 || sif.running !== 1'b1 || sif.halt_cause !== 2'b00 ||
        sif.phase_en !== 4'b0001) begin
      n_fail++; $display("FAIL restart: got count=%0d running=%b cause=%b pe=%b expected 0/1/00/0001",
                         sif.cycle_count, sif.running, sif.halt_cause, sif.phase_en);
    end
  endtask

  task automatic test_abort();
    tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !(m_cnt == 4 && m_off == 8); i++) begin
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL abort_outputs cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      tick(1'b0, 1'b0, $urandom | 32'd1, 1'b0, 1'b0);
    end
    n_checks++;
    if (sif.phase_en !== 4'b0100) begin
      n_fail++; $display("FAIL abort_setup: got pe=%b expected 0100", sif.phase_en);
    end
    tick(1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
    n_checks++;
    if (sif.phase_en !== 4'd0 || sif.halt_cause !== 2'b11 || sif.cycle_count !== 16'd4 ||
        sif.running !== 1'b0 || sif.halted !== !DUMP) begin
      n_fail++; $display("FAIL abort_mid: got pe=%b cause=%b count=%0d halted=%b expected 0000/11/4/%b",
                         sif.phase_en, sif.halt_cause, sif.cycle_count, sif.halted, !DUMP);
    end
  endtask

  task automatic test_abort_step_end();
    tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !(m_cnt == 2 && m_off == STEP - 1); i++) begin
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL abort_end_outputs cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b1, 32'd0, 1'b0, 1'b0);  // third nop coincides with abort
    n_checks++;
    if (sif.halt_cause !== 2'b11 || sif.cycle_count !== 16'd3 || sif.phase_en !== 4'd0) begin
      n_fail++; $display("FAIL abort_step_end: got cause=%b count=%0d pe=%b expected 11/3/0000",
                         sif.halt_cause, sif.cycle_count, sif.phase_en);
    end
  endtask

  task automatic test_reset_midrun();
    tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 32'd1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 32'd0, 1'b1, 1'b1);
    n_checks++;
    if (obs_vec() !== 31'd0) begin
      n_fail++; $display("FAIL reset_midrun: got %h expected 0", obs_vec());
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_outputs cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      ins = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      tick($urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0, ins, $urandom_range(0, 1) == 1,
           $urandom_range(0, 999) == 0);
    end
  endtask

`ifdef MIPS_PHASE_SEQ_DUMP_EN
  task automatic test_dump();
    int seen[32];
    int bad;
    bit rdy;
    foreach (seen[k]) seen[k] = 0;
    tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL dump_outputs cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (sif.halted === 1'b1) break;
      rdy = (i % 2) == 0;
      if (rdy && sif.dump_valid === 1'b1) seen[sif.dump_addr]++;
      tick(1'b0, 1'b0, 32'd0, rdy, 1'b0);
    end
    bad = 0;
    foreach (seen[k]) if (seen[k] != 1) bad++;
    n_checks++;
    if (bad != 0 || sif.halted !== 1'b1 || sif.dump_valid !== 1'b0) begin
      n_fail++; $display("FAIL dump_sweep: got bad_indices=%0d halted=%b valid=%b expected 0/1/0",
                         bad, sif.halted, sif.dump_valid);
    end
  endtask
`else
  task automatic test_no_dump();
    int n_valid;
    n_valid = 0;
    tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 32'd1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 32'd1, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (sif.dump_valid !== 1'b0) n_valid++;
      tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    end
    n_checks++;
    if (n_valid != 0 || sif.halted !== 1'b1) begin
      n_fail++; $display("FAIL no_dump: got valid_cycles=%0d halted=%b expected 0/1", n_valid,
                         sif.halted);
    end
  endtask
`endif

  initial begin
    sif.start = 1'b0; sif.abort = 1'b0; sif.instruction = 32'd0; sif.dump_ready = 1'b0;
    test_reset();
    test_phase_pattern();
    test_nop_halt();
    test_step_limit();
    test_abort();
    test_abort_step_end();
    test_reset_midrun();
    test_random();
`ifdef MIPS_PHASE_SEQ_DUMP_EN
    test_dump();
`else
    test_no_dump();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
